// File: rtl/pfc_cmd_sequencer.sv
// Round-robin sharer of the PFC command bus between NUM_REQ requesters.
// Each grant runs setup / strobe / capture and returns resp with a done pulse.
module pfc_cmd_sequencer #(
  parameter int NUM_REQ       = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [2*NUM_REQ-1:0]    req_bank,
  input  logic [2*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [31:0]             rdata,
  output logic                    busy,
  output logic [36:0]             pfc_cmd,
  input  logic [31:0]             pfc_resp
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt;
  logic          found;
  logic [3:0]    cnt;
  logic          wr;
  logic [35:0]   cmd_q;

  // Round-robin pick: first requester upward from ptr+1, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    nxt   = ptr;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[PW'(idx)]) begin
        nxt   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  // Sequencer: latch the granted command, hold it, strobe, capture, done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr   <= PW'(NUM_REQ - 1);
      cnt   <= '0;
      wr    <= 1'b0;
      cmd_q <= '0;
      rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            ptr   <= nxt;
            wr    <= req_write[nxt];
            cmd_q <= {req_bank[2*nxt +: 2],
                      req_addr[2*nxt +: 2],
                      req_wdata[32*nxt +: 32]};
            cnt   <= 4'(SETTLE_CYCLES - 1);
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == 4'd0) state <= S_STROBE;
          else             cnt   <= cnt - 4'd1;
        end
        S_STROBE:  state <= S_CAPTURE;
        S_CAPTURE: begin
          rdata <= pfc_resp;
          state <= S_DONE;
        end
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Done pulse goes only to the requester that owns the access.
  always_comb begin
    req_done = '0;
    if (state == S_DONE) req_done[ptr] = 1'b1;
  end

  // Strobe derives from state, so an async reset drops it at once.
  assign pfc_cmd = {(state == S_STROBE) & wr, cmd_q};
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_pfc_cmd_sequencer.sv
// Bench for pfc_cmd_sequencer: directed scenarios plus randomized
// round-robin traffic against a register-file reference model.
module tb_pfc_cmd_sequencer;
  localparam int NR = 2;
  localparam int ST = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid, req_write, req_done;
  logic [2*NR-1:0]  req_bank, req_addr;
  logic [32*NR-1:0] req_wdata;
  logic [31:0]      rdata, pfc_resp;
  logic             busy;
  logic [36:0]      pfc_cmd;

  logic [NR-1:0]    v3, w3, d3;
  logic [2*NR-1:0]  b3, a3;
  logic [32*NR-1:0] wd3;
  logic [31:0]      rd3, resp3;
  logic             busy3;
  logic [36:0]      cmd3;

  int checks = 0;
  int errors = 0;
  int rr_ptr = NR - 1;
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  logic prev_stb = 1'b0;

  always #5 clk = ~clk;

  pfc_cmd_sequencer #(.NUM_REQ(NR), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_bank(req_bank), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done),
    .rdata(rdata), .busy(busy),
    .pfc_cmd(pfc_cmd), .pfc_resp(pfc_resp)
  );

  pfc_cmd_sequencer #(.NUM_REQ(NR), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(rst_n),
    .req_valid(v3), .req_write(w3),
    .req_bank(b3), .req_addr(a3),
    .req_wdata(wd3), .req_done(d3),
    .rdata(rd3), .busy(busy3),
    .pfc_cmd(cmd3), .pfc_resp(resp3)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 12) ? 32'hCAFEF00D : 32'h0BAD0000 + 32'(i);
  endfunction

  // PFC bank model: combinational read, write on strobe.
  assign pfc_resp = mem[pfc_cmd[35:32]];
  assign resp3    = {cmd3[35:32], 28'h0000123};

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (pfc_cmd[36]) begin
      mem[pfc_cmd[35:32]] <= pfc_cmd[31:0];
    end
  end

  // Strobe must never last two consecutive cycles.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (prev_stb && pfc_cmd[36]) begin
        errors++;
        $display("FAIL strobe_twice got 1 exp 0 at %0t", $time);
      end
    end
    prev_stb <= pfc_cmd[36];
  end

  task automatic init_shadow();
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    rr_ptr = NR - 1;
  endtask

  task automatic run_single(input int r, input logic wr,
                            input logic [1:0] bank, input logic [1:0] addr,
                            input logic [31:0] wd, input string nm);
    logic [31:0] exp_rd;
    logic [NR-1:0] exp_done;
    logic exp_stb;
    int idx;
    idx = int'({bank, addr});
    exp_rd = wr ? wd : shadow[idx];
    req_write[r] = wr;
    req_bank[2*r +: 2] = bank;
    req_addr[2*r +: 2] = addr;
    req_wdata[32*r +: 32] = wd;
    req_valid[r] = 1'b1;
    for (int c = 1; c <= ST + 3; c++) begin
      @(negedge clk);
      exp_stb = wr && (c == ST + 1);
      exp_done = (c == ST + 3) ? NR'(1 << r) : '0;
      checks++;
      if (pfc_cmd[36] !== exp_stb) begin
        errors++;
        $display("FAIL %s strobe c%0d got %b exp %b", nm, c, pfc_cmd[36], exp_stb);
      end
      checks++;
      if (pfc_cmd[35:0] !== {bank, addr, wd}) begin
        errors++;
        $display("FAIL %s cmd c%0d got %h exp %h", nm, c, pfc_cmd[35:0], {bank, addr, wd});
      end
      checks++;
      if (req_done !== exp_done) begin
        errors++;
        $display("FAIL %s done c%0d got %b exp %b", nm, c, req_done, exp_done);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy c%0d got %b exp 1", nm, c, busy);
      end
    end
    checks++;
    if (rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s rdata got %h exp %h", nm, rdata, exp_rd);
    end
    req_valid[r] = 1'b0;
    if (wr) shadow[idx] = wd;
    rr_ptr = r;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_done !== '0 || rdata !== exp_rd) begin
      errors++;
      $display("FAIL %s idle got busy=%b done=%b rdata=%h exp 0 0 %h",
               nm, busy, req_done, rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] d0, d1;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_bank = '0;
    req_addr = '0; req_wdata = '0;
    v3 = '0; w3 = '0; b3 = '0; a3 = '0; wd3 = '0;
    init_shadow();
    repeat (3) @(negedge clk);
    checks++;
    if (pfc_cmd !== '0) begin
      errors++; $display("FAIL reset_cmd got %h exp 0", pfc_cmd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", busy);
    end
    checks++;
    if (req_done !== '0) begin
      errors++; $display("FAIL reset_done got %b exp 0", req_done);
    end
    checks++;
    if (rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got %h exp 0", rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    d0 = $urandom; d1 = $urandom;
    req_write = '1;
    req_bank = {2'd0, 2'd0}; req_addr = {2'd3, 2'd1};
    req_wdata = {d1, d0};
    req_valid = '1;
    n = 0;
    do begin @(negedge clk); n++; end while (req_done === '0 && n < 12);
    checks++;
    if (req_done !== 2'b01 || n != ST + 3) begin
      errors++;
      $display("FAIL first_grant got done=%b lat=%0d exp 01 %0d", req_done, n, ST + 3);
    end
    checks++;
    if (rdata !== d0) begin
      errors++; $display("FAIL first_grant_rdata got %h exp %h", rdata, d0);
    end
    req_valid = '0;
    shadow[1] = d0;
    rr_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_single(0, 1'b1, 2'd2, 2'd1, 32'h12345678, "write");
  endtask

  task automatic test_read();
    run_single(1, 1'b0, 2'd3, 2'd0, 32'h0, "read");
  endtask

  task automatic test_back_to_back();
    int got[$];
    int last_stb, cyc, e;
    logic [NR-1:0] prev_done;
    logic [31:0] d [NR];
    d[0] = $urandom; d[1] = $urandom;
    req_write = '1;
    req_bank = {2'd2, 2'd1}; req_addr = {2'd2, 2'd0};
    req_wdata = {d[1], d[0]};
    req_valid = '1;
    last_stb = -100; cyc = 0; prev_done = '0;
    while (got.size() < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (pfc_cmd[36]) begin
        checks++;
        if (cyc - last_stb < ST + 4) begin
          errors++;
          $display("FAIL b2b_stb_gap got %0d exp >=%0d", cyc - last_stb, ST + 4);
        end
        last_stb = cyc;
      end
      if (req_done !== '0) begin
        e = (rr_ptr + 1) % NR;
        checks++;
        if (req_done !== NR'(1 << e)) begin
          errors++; $display("FAIL b2b_order got %b exp %b", req_done, NR'(1 << e));
        end
        checks++;
        if (prev_done !== '0) begin
          errors++; $display("FAIL b2b_done_width got %b exp 0", prev_done);
        end
        checks++;
        if (rdata !== d[e]) begin
          errors++; $display("FAIL b2b_rdata got %h exp %h", rdata, d[e]);
        end
        rr_ptr = e;
        got.push_back(e);
        if (got.size() == 4) req_valid = '0;
      end
      prev_done = req_done;
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL b2b_timeout got %0d exp 4", got.size());
    end
    req_valid = '0;
    shadow[4] = d[0];
    shadow[10] = d[1];
    @(negedge clk);
  endtask

  task automatic test_wdata_change();
    logic [31:0] a;
    a = 32'hA5A50F0F;
    req_write[0] = 1'b1;
    req_bank[1:0] = 2'd1; req_addr[1:0] = 2'd3;
    req_wdata[31:0] = a;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_wdata[31:0] = 32'hFFFFFFFF;
    req_bank[1:0] = 2'd0;
    @(negedge clk);
    checks++;
    if (pfc_cmd !== {1'b1, 2'd1, 2'd3, a}) begin
      errors++; $display("FAIL hold_strobe got %h exp %h", pfc_cmd, {1'b1, 2'd1, 2'd3, a});
    end
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_done !== 2'b01 || rdata !== a) begin
      errors++;
      $display("FAIL hold_done got %b %h exp 01 %h", req_done, rdata, a);
    end
    shadow[7] = a;
    rr_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_settle3();
    logic exp_stb;
    logic [NR-1:0] exp_done;
    w3[0] = 1'b1; b3[1:0] = 2'd2; a3[1:0] = 2'd3;
    wd3[31:0] = 32'h5EED5EED;
    v3[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_stb = (c == 4);
      exp_done = (c == 6) ? 2'b01 : 2'b00;
      checks++;
      if (cmd3[36] !== exp_stb || d3 !== exp_done) begin
        errors++;
        $display("FAIL settle3 c%0d got stb=%b done=%b exp %b %b",
                 c, cmd3[36], d3, exp_stb, exp_done);
      end
      if (c == 6) begin
        v3[0] = 1'b0;
        checks++;
        if (rd3 !== {4'hB, 28'h0000123}) begin
          errors++; $display("FAIL settle3_rdata got %h exp %h", rd3, {4'hB, 28'h0000123});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    req_write[0] = 1'b1;
    req_bank[1:0] = 2'd0; req_addr[1:0] = 2'd2;
    req_wdata[31:0] = $urandom;
    req_valid[0] = 1'b1;
    repeat (ST + 1) @(negedge clk);
    checks++;
    if (pfc_cmd[36] !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got %b exp 1", pfc_cmd[36]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pfc_cmd !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got %h %b exp 0 0", pfc_cmd, busy);
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_done !== '0) begin
        errors++; $display("FAIL rstmid_done got %b exp 0", req_done);
      end
    end
    init_shadow();
    rst_n = 1'b1;
    run_single(0, 1'b1, 2'd1, 2'd1, 32'h0BADBEEF, "after_rst");
  endtask

  task automatic test_random();
    logic [NR-1:0] pend;
    logic fw [NR];
    logic [1:0] fb [NR], fa [NR];
    logic [31:0] fd [NR];
    logic [31:0] exp_rd;
    int e, n, k, j, idx;
    logic first;
    for (int rnd = 0; rnd < 30; rnd++) begin
      pend = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        fw[i] = 1'($urandom); fb[i] = 2'($urandom);
        fa[i] = 2'($urandom); fd[i] = $urandom;
        req_write[i] = fw[i];
        req_bank[2*i +: 2] = fb[i];
        req_addr[2*i +: 2] = fa[i];
        req_wdata[32*i +: 32] = fd[i];
      end
      req_valid = pend;
      first = 1'b1;
      while (pend != '0) begin
        e = -1;
        for (k = NR; k >= 1; k--) begin
          j = (rr_ptr + k) % NR;
          if (pend[j]) e = j;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (req_done === '0 && n < 20);
        checks++;
        if (n != (first ? ST + 3 : ST + 4)) begin
          errors++;
          $display("FAIL rnd_latency got %0d exp %0d", n, first ? ST + 3 : ST + 4);
        end
        checks++;
        if (req_done !== NR'(1 << e)) begin
          errors++; $display("FAIL rnd_grant got %b exp %b", req_done, NR'(1 << e));
        end
        idx = int'({fb[e], fa[e]});
        exp_rd = fw[e] ? fd[e] : shadow[idx];
        checks++;
        if (rdata !== exp_rd) begin
          errors++; $display("FAIL rnd_rdata got %h exp %h", rdata, exp_rd);
        end
        if (fw[e]) shadow[idx] = fd[e];
        req_valid[e] = 1'b0;
        pend[e] = 1'b0;
        rr_ptr = e;
        first = 1'b0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_wdata_change();
    test_settle3();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
